// File: rtl/spi_mem_pkg.sv
// Shared opcodes, frame geometry and FSM encoding for the SPI serial-SRAM controller.
package spi_mem_pkg;

  localparam logic [7:0] SPI_CMD_READ  = 8'h03;
  localparam logic [7:0] SPI_CMD_WRITE = 8'h02;

  localparam int CMD_BITS  = 8;
  localparam int ADDR_BITS = 24;
  localparam int DATA_BITS = 16;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DATA,
    DONE
  } spi_state_e;

  function automatic logic [7:0] spi_opcode(input logic write);
    return write ? SPI_CMD_WRITE : SPI_CMD_READ;
  endfunction

endpackage

// File: rtl/spi_mem_controller_clk_divider.sv
// Mode-0 serial clock generator: low for CLK_DIV cycles, then high for CLK_DIV cycles,
// with single-cycle ticks marking the edges that raise and lower spi_clk.
module spi_clk_divider #(
  parameter int CLK_DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic spi_clk,
  output logic rise_tick,
  output logic fall_tick
);

  localparam logic [7:0] HALF_LAST = 8'(CLK_DIV - 1);

  logic [7:0] hp_cnt;
  logic       wrap;

  assign wrap      = en && (hp_cnt == HALF_LAST);
  assign rise_tick = wrap && !spi_clk;
  assign fall_tick = wrap && spi_clk;

  // Dropping en parks the clock low so every frame starts from a clean low phase.
  always_ff @(posedge clk) begin
    if (!rst_n || !en) begin
      hp_cnt  <= '0;
      spi_clk <= 1'b0;
    end else if (wrap) begin
      hp_cnt  <= '0;
      spi_clk <= ~spi_clk;
    end else begin
      hp_cnt <= hp_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/spi_mem_controller.sv
// SPI mode-0 initiator: one request moves one {opcode, addr, data} frame to or from
// a 23LC-style serial SRAM, MSB first, returning read data on the done pulse.
module spi_mem_controller
  import spi_mem_pkg::*;
#(
  parameter int CLK_DIV    = 1,
  parameter int ADDR_WIDTH = 24,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  spi_clk,
  output logic                  spi_mosi,
  input  logic                  spi_miso,
  output logic                  spi_select
);

  localparam int FRAME_BITS = CMD_BITS + ADDR_WIDTH + DATA_WIDTH;
  localparam int CNT_W      = $clog2(FRAME_BITS);

  localparam logic [CNT_W-1:0] LAST_CMD  = CNT_W'(CMD_BITS - 1);
  localparam logic [CNT_W-1:0] LAST_ADDR = CNT_W'(CMD_BITS + ADDR_WIDTH - 1);
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(FRAME_BITS - 1);

  spi_state_e            state;
  spi_state_e            state_next;
  logic [FRAME_BITS-1:0] sreg;
  logic [CNT_W-1:0]      bit_cnt;
  logic                  wr_q;
  logic                  shifting;
  logic                  fall_tick;
  logic                  unused_rise_tick;

  spi_clk_divider #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (shifting),
    .spi_clk  (spi_clk),
    .rise_tick(unused_rise_tick),
    .fall_tick(fall_tick)
  );

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: the default assignment first keeps this combinational and latch-free.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = CMD;
      CMD:     if (fall_tick && bit_cnt == LAST_CMD)  state_next = ADDR;
      ADDR:    if (fall_tick && bit_cnt == LAST_ADDR) state_next = DATA;
      DATA:    if (fall_tick && bit_cnt == LAST_DATA) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // DONE keeps select high for one hold cycle with the serial clock parked low.
  always_comb begin
    spi_select = 1'b0;
    shifting   = 1'b0;
    unique case (state)
      CMD, ADDR, DATA: begin
        spi_select = 1'b1;
        shifting   = 1'b1;
      end
      DONE:    spi_select = 1'b1;
      default: ;
    endcase
  end

  assign busy     = spi_select;
  assign spi_mosi = shifting & sreg[FRAME_BITS-1];

  // A read frame carries zeros in its data slot, so mosi stays low while data returns.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sreg    <= '0;
      bit_cnt <= '0;
      wr_q    <= 1'b0;
      rdata   <= '0;
      done    <= 1'b0;
    end else begin
      done <= (state == DONE);
      if (state == IDLE) begin
        bit_cnt <= '0;
        if (start) begin
          sreg <= {spi_opcode(write), addr, {DATA_WIDTH{write}} & wdata};
          wr_q <= write;
        end
      end else if (fall_tick) begin
        sreg <= {sreg[FRAME_BITS-2:0], spi_miso};
        if (bit_cnt != LAST_DATA) bit_cnt <= bit_cnt + CNT_W'(1);
      end
      if (state == DONE && !wr_q) rdata <= sreg[DATA_WIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_spi_mem_controller.sv
// Directed bench: two controllers (CLK_DIV=1 and 2), each on its own behavioural serial SRAM.
module tb_spi_mem_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  start_r, write_r;
  logic [23:0] addr_r  [2];
  logic [15:0] wdata_r [2];
  logic [15:0] rdata_w [2];
  logic [1:0]  busy_w, done_w, sck_w, mosi_w, sel_w;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic miso;

    spi_mem_controller #(.CLK_DIV(g + 1)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start_r[g]),
      .write     (write_r[g]),
      .addr      (addr_r[g]),
      .wdata     (wdata_r[g]),
      .rdata     (rdata_w[g]),
      .busy      (busy_w[g]),
      .done      (done_w[g]),
      .spi_clk   (sck_w[g]),
      .spi_mosi  (mosi_w[g]),
      .spi_miso  (miso),
      .spi_select(sel_w[g])
    );

    // Serial SRAM responder: shifts mosi on rising spi_clk, presents read data for the high phase.
    initial begin : sram
      logic [7:0]  mem [256];
      logic [47:0] rx;
      logic [15:0] word;
      logic [7:0]  cmd, a;
      int          nbits;
      foreach (mem[i]) mem[i] = 8'h00;
      mem[8'h10] = 8'h12; mem[8'h11] = 8'h34;
      mem[8'h30] = 8'h56; mem[8'h31] = 8'h78;
      rx = '0; word = '0; cmd = '0; a = '0; nbits = 0; miso = 1'b0;
      forever begin
        @(posedge sck_w[g] or negedge sel_w[g]);
        if (!sel_w[g]) begin
          nbits = 0;
          miso  = 1'b0;
        end else begin
          rx = {rx[46:0], mosi_w[g]};
          nbits++;
          if (nbits == 32) begin
            cmd  = rx[31:24];
            a    = rx[7:0];
            word = {mem[a], mem[a + 8'd1]};
          end
          if (cmd == 8'h03 && nbits >= 33 && nbits <= 48) miso = word[4'(48 - nbits)];
          if (cmd == 8'h02 && nbits == 48) begin
            mem[a]        = rx[15:8];
            mem[a + 8'd1] = rx[7:0];
          end
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the next posedge is acceptance (cycle 0). Returns at the done
  // cycle's negedge, or after the budget with done_cyc = -1.
  task automatic run(input int g, input logic wr, input logic [23:0] a, input logic [15:0] wd,
                     input int poke, output int done_cyc, output int sel_cyc,
                     output logic [63:0] cap, output int nb);
    int   c;
    logic prev;
    start_r[g] = 1'b1; write_r[g] = wr; addr_r[g] = a; wdata_r[g] = wd;
    @(negedge clk);
    write_r[g] = ~wr; addr_r[g] = ~a; wdata_r[g] = ~wd;
    c = 1; sel_cyc = 0; done_cyc = -1; cap = '0; nb = 0; prev = 1'b0;
    while (c < 400) begin
      if (done_w[g]) begin
        done_cyc = c;
        break;
      end
      if (sel_w[g]) sel_cyc++;
      if (sck_w[g] && !prev) begin
        cap = {cap[62:0], mosi_w[g]};
        nb++;
      end
      prev = sck_w[g];
      start_r[g] = (c == poke);
      @(negedge clk);
      c++;
    end
    start_r[g] = 1'b0;
  endtask

  // Watches n cycles for stray done pulses and new select assertions.
  task automatic quiet(input int g, input int n, output int dones, output int rises);
    logic prev;
    dones = 0; rises = 0; prev = sel_w[g];
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done_w[g]) dones++;
      if (sel_w[g] && !prev) rises++;
      prev = sel_w[g];
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int          dc, sc, nb, dn, rs;
    logic [63:0] cap;

    rst_n = 1'b0;
    start_r = 2'b11; write_r = 2'b00;
    addr_r[0] = 24'h10; addr_r[1] = 24'h10; wdata_r[0] = '0; wdata_r[1] = '0;
    repeat (5) @(negedge clk);
    check("reset_select", 64'(sel_w), 64'(0));
    check("reset_busy_done", 64'({busy_w, done_w}), 64'(0));
    check("reset_sck_mosi", 64'({sck_w, mosi_w}), 64'(0));
    check("reset_rdata", 64'({rdata_w[0], rdata_w[1]}), 64'(0));
    start_r = 2'b00;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // CLK_DIV=2 write of 0xBEEF to 0x20
    run(1, 1'b1, 24'h000020, 16'hBEEF, 0, dc, sc, cap, nb);
    check("wr_done_cycle", 64'(dc), 64'(194));
    check("wr_select_cycles", 64'(sc), 64'(193));
    check("wr_mosi_bits", 64'(nb), 64'(48));
    check("wr_mosi_stream", 64'(cap[47:0]), 64'(48'h020000_20BEEF));
    check("wr_done_idle", 64'({sel_w[1], busy_w[1], sck_w[1]}), 64'(0));
    check("wr_rdata_kept", 64'(rdata_w[1]), 64'(0));

    @(negedge clk);
    run(1, 1'b0, 24'h000020, 16'h0000, 0, dc, sc, cap, nb);
    check("rd20_done_cycle", 64'(dc), 64'(194));
    check("rd20_mosi_stream", 64'(cap[47:0]), 64'(48'h030000_200000));
    check("rd20_rdata", 64'(rdata_w[1]), 64'(16'hBEEF));

    // Write of 0x1111 to 0x20 aborted by reset in cycle 50
    @(negedge clk);
    start_r[1] = 1'b1; write_r[1] = 1'b1; addr_r[1] = 24'h20; wdata_r[1] = 16'h1111;
    @(negedge clk);
    start_r[1] = 1'b0;
    repeat (49) @(negedge clk);
    check("abort_busy_before", 64'(sel_w[1]), 64'(1));
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_select_sck", 64'({sel_w[1], sck_w[1], busy_w[1]}), 64'(0));
    check("abort_rdata_reset", 64'(rdata_w[1]), 64'(0));
    rst_n = 1'b1;
    quiet(1, 250, dn, rs);
    check("abort_no_done", 64'(dn), 64'(0));
    check("abort_no_restart", 64'(rs), 64'(0));
    run(1, 1'b0, 24'h000020, 16'h0000, 0, dc, sc, cap, nb);
    check("abort_old_data", 64'(rdata_w[1]), 64'(16'hBEEF));

    // CLK_DIV=1 read of 0x10 with a stray start at cycle 40
    @(negedge clk);
    run(0, 1'b0, 24'h000010, 16'h0000, 40, dc, sc, cap, nb);
    check("rd10_done_cycle", 64'(dc), 64'(98));
    check("rd10_select_cycles", 64'(sc), 64'(97));
    check("rd10_mosi_stream", 64'(cap[47:0]), 64'(48'h030000_100000));
    check("rd10_rdata", 64'(rdata_w[0]), 64'(16'h1234));
    quiet(0, 150, dn, rs);
    check("poke_no_second_done", 64'(dn), 64'(0));
    check("poke_no_second_select", 64'(rs), 64'(0));

    // Back-to-back: second start in the done cycle
    @(negedge clk);
    run(0, 1'b0, 24'h000030, 16'h0000, 0, dc, sc, cap, nb);
    check("b2b_first_done", 64'(dc), 64'(98));
    check("b2b_first_rdata", 64'(rdata_w[0]), 64'(16'h5678));
    check("b2b_gap_select_low", 64'(sel_w[0]), 64'(0));
    run(0, 1'b0, 24'h000010, 16'h0000, 0, dc, sc, cap, nb);
    check("b2b_second_done", 64'(dc), 64'(98));
    check("b2b_second_select", 64'(sc), 64'(97));
    check("b2b_second_rdata", 64'(rdata_w[0]), 64'(16'h1234));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_mem_controller.md
Name: spi_mem_controller

Overview:
- SPI mode-0 initiator that lets the core fetch and store 16-bit words in an external 23LC-style serial SRAM.
- Sits between the core's memory request port and the uio SPI pins: spi_mosi on uio_out[0], spi_select on uio_out[1], spi_clk on uio_out[2], spi_miso on uio_in[3].
- Each request issues one complete transaction: 8-bit command, 24-bit address, 16 data bits.
- Counterpart of the sim_spi_ram responder model used by the benches.

Parameters:
- CLK_DIV, 1, clk cycles per spi_clk half-period; legal range 1..255.
- ADDR_WIDTH, 24, byte address width sent on the wire.
- DATA_WIDTH, 16, data bits per transaction; must be a multiple of 8.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  request strobe; accepted only while idle
- write  in  1  1 = write transaction, 0 = read transaction
- addr  in  ADDR_WIDTH  byte address
- wdata  in  DATA_WIDTH  write data
- rdata  out  DATA_WIDTH  read data; holds its last value
- busy  out  1  high from the cycle after acceptance until done
- done  out  1  one-cycle completion pulse
- spi_clk  out  1  serial clock; idles low
- spi_mosi  out  1  serial data to memory
- spi_miso  in  1  serial data from memory
- spi_select  out  1  chip select, active high (board inverts it)

Behaviour:
- Reset values: spi_select=0, spi_clk=0, spi_mosi=0, busy=0, done=0, rdata=0, state=IDLE.
- A reset asserted mid-transaction aborts it on that clock edge. select drops, no done pulse is produced, and rdata keeps its reset value of 0.
- FSM states:
  - IDLE -> CMD: on start=1. write, addr and wdata are latched into a 48-bit shift register as {opcode, addr, wdata}.
  - CMD -> ADDR after 8 bits. Opcode is 0x03 for a read, 0x02 for a write.
  - ADDR -> DATA after 24 bits.
  - DATA -> DONE after 16 bits.
  - DONE -> IDLE after 1 cycle.
- Input changes after acceptance are ignored. start while busy is ignored and is not queued.
- Bit framing: MSB first. The data word goes high byte first: the high byte is at addr and the low byte at addr+1.
- Bit timing (mode 0):
  - For each bit, spi_clk is low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - spi_mosi updates only while spi_clk is low. The first bit is valid on the first select-high cycle.
  - spi_miso is sampled on the clk edge that ends each high phase, i.e. the same edge that drives spi_clk low.
  - During read DATA, spi_mosi is 0. During write DATA, spi_miso is ignored.
- Cycle budget, with the acceptance edge at cycle 0:
  - spi_select and busy are high for cycles 1 .. 96*CLK_DIV+1. That is 96*CLK_DIV SPI cycles plus 1 hold cycle with spi_clk=0 (DONE state).
  - In cycle 96*CLK_DIV+2: spi_select=0, busy=0, done=1.
  - For a read, rdata is updated in that same cycle. A write leaves rdata unchanged.
- Back-to-back: start may be high in the done cycle and is accepted then. The minimum select-low gap is 1 cycle.
- Address wrap-around belongs to the memory. The controller sends addr unmodified.
- Counters: a half-period counter (8 bits) and a bit counter (6 bits, 0..47). The bit counter saturates and never wraps inside a transaction.

Decomposition:
- Package spi_mem_pkg holds:
  - SPI_CMD_READ = 8'h03 and SPI_CMD_WRITE = 8'h02.
  - CMD_BITS = 8, plus the ADDR and DATA bit counts.
  - State enum {IDLE, CMD, ADDR, DATA, DONE}.
- One sub-module, spi_clk_divider: generates the spi_clk level plus one-cycle rise_tick and fall_tick from CLK_DIV. It is enabled only while select is high and is cleared by rst_n.
- The shift register and FSM stay in spi_mem_controller.

Test Plan:
- Reset: hold rst_n=0 for 5 cycles -> all outputs 0. start during reset -> no select.
- Read, CLK_DIV=1, addr=0x000010, memory bytes 0x12,0x34 -> MOSI stream 0x03,0x00,0x00,0x10. done at cycle 98, rdata=0x1234, select high exactly 97 cycles.
- Write, CLK_DIV=2, addr=0x000020, wdata=0xBEEF -> MOSI stream 0x02,0x00,0x00,0x20,0xBE,0xEF. Memory reads back 0xBEEF, done at cycle 194, rdata unchanged.
- start pulsed at cycle 40 of an active read -> ignored. Exactly one done, and no second select assertion.
- rst_n low at cycle 50 of a write -> select and spi_clk 0 the next cycle, no done. A following read of the same address returns old data.
- Back-to-back: second start in the done cycle -> select low for exactly 1 cycle, both dones present, both rdata values correct.
